// File: rtl/uart_link_pkg.sv
// Shared definitions for the CoreUART host-side link sequencer.
// Holds the sequencer state encoding and the guard counter width.
package uart_link_pkg;

    // Sequencer states: IDLE selects work, WR/RD are single strobe cycles,
    // GUARD masks the UART's registered status flags after a strobe.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWr    = 2'd1,
        StRd    = 2'd2,
        StGuard = 2'd3
    } link_state_e;

    // Wide enough for the largest legal guard length (7).
    localparam int unsigned GuardCntW = 3;

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin arbiter with packet lock for the shared UART transmitter.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req[1:0]     requester valids
//   launch       a write to the selected requester was committed this cycle
//   accept       the committed byte is being accepted (ready pulse cycle)
//   accept_last  the accepted byte ends its packet
//   sel          requester to serve next (combinational)
//   grant        current TX owner
//   lock         packet in progress; only the owner may be served
module uart_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       launch,
    input  logic       accept,
    input  logic       accept_last,
    output logic       sel,
    output logic       grant,
    output logic       lock
);

    logic grant_q;
    logic lock_q;
    logic ptr_q;    // preferred requester when unlocked

    always_comb begin
        sel = ptr_q;
        if (lock_q) begin
            sel = grant_q;
        end else if (req[ptr_q]) begin
            sel = ptr_q;
        end else if (req[~ptr_q]) begin
            sel = ~ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= 1'b0;
            lock_q  <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            if (launch) begin
                grant_q <= sel;
            end
            if (accept) begin
                lock_q <= ~accept_last;
                // The pointer only moves once the owner's packet has ended.
                if (accept_last) begin
                    ptr_q <= ~grant_q;
                end
            end
        end
    end

    assign grant = grant_q;
    assign lock  = lock_q;

endmodule

// File: rtl/uart_link_ctrl.sv
// Host-side sequencer for the CoreUART byte interface.
// Shares the UART transmitter between two byte-stream requesters (round-robin
// with packet lock) and drains the receiver into a one-entry buffer that keeps
// the parity/framing flags. Sole driver of the UART CSN/WEN/OEN/DATA_IN pins.
// Ports:
//   CLK, RESET_N                    clock, asynchronous active-low reset
//   txN_data/valid/last/ready       requester byte streams (N = 0, 1)
//   rx_data/perr/ferr/valid/ready   received byte buffer (valid/ready)
//   uart_csn/wen/oen/din            registered active-low strobes and write data
//   uart_dout/txrdy/rxrdy/perr/ferr UART read data and status
//   grant, lock                     current TX owner and packet-in-progress flag
module uart_link_ctrl
    import uart_link_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES = 2,
    parameter bit          RX_PRIORITY  = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] tx0_data,
    input  logic       tx0_valid,
    input  logic       tx0_last,
    output logic       tx0_ready,
    input  logic [7:0] tx1_data,
    input  logic       tx1_valid,
    input  logic       tx1_last,
    output logic       tx1_ready,
    output logic [7:0] rx_data,
    output logic       rx_perr,
    output logic       rx_ferr,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       uart_csn,
    output logic       uart_wen,
    output logic       uart_oen,
    output logic [7:0] uart_din,
    input  logic [7:0] uart_dout,
    input  logic       uart_txrdy,
    input  logic       uart_rxrdy,
    input  logic       uart_perr,
    input  logic       uart_ferr,
    output logic       grant,
    output logic       lock
);

    localparam logic [GuardCntW-1:0] GuardLoad = GuardCntW'(GUARD_CYCLES);

    link_state_e          state_q, state_d;
    logic [GuardCntW-1:0] cnt_q;

    logic       csn_q, wen_q, oen_q;
    logic [7:0] din_q;
    logic       tx0_ready_q, tx1_ready_q;
    logic       last_q;     // last flag of the byte being written

    logic       rx_valid_q;
    logic [7:0] rx_data_q;
    logic       rx_perr_q, rx_ferr_q;

    logic       sel;
    logic       sel_valid, sel_last;
    logic [7:0] sel_data;
    logic       rx_elig, tx_elig;
    logic       go_wr, go_rd;

    uart_rr_arb2 u_arb (
        .clk         (CLK),
        .rst_n       (RESET_N),
        .req         ({tx1_valid, tx0_valid}),
        .launch      (go_wr),
        .accept      (state_q == StWr),
        .accept_last (last_q),
        .sel         (sel),
        .grant       (grant),
        .lock        (lock)
    );

    assign sel_valid = sel ? tx1_valid : tx0_valid;
    assign sel_last  = sel ? tx1_last  : tx0_last;
    assign sel_data  = sel ? tx1_data  : tx0_data;

    // A full buffer being emptied this cycle can take the next byte right away.
    assign rx_elig = uart_rxrdy && (!rx_valid_q || rx_ready);
    assign tx_elig = uart_txrdy && sel_valid;

    always_comb begin
        state_d = state_q;
        go_wr   = 1'b0;
        go_rd   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_elig && (!tx_elig || RX_PRIORITY)) begin
                    go_rd   = 1'b1;
                    state_d = StRd;
                end else if (tx_elig) begin
                    go_wr   = 1'b1;
                    state_d = StWr;
                end
            end
            StWr, StRd: state_d = StGuard;
            StGuard: begin
                if (cnt_q <= GuardCntW'(1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StWr || state_q == StRd) begin
                cnt_q <= GuardLoad;
            end else if (state_q == StGuard && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Strobes are registered from the IDLE decision so the pins are glitch-free.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            csn_q       <= 1'b1;
            wen_q       <= 1'b1;
            oen_q       <= 1'b1;
            din_q       <= 8'h00;
            tx0_ready_q <= 1'b0;
            tx1_ready_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            csn_q       <= ~(go_wr | go_rd);
            wen_q       <= ~go_wr;
            oen_q       <= ~go_rd;
            tx0_ready_q <= go_wr & ~sel;
            tx1_ready_q <= go_wr & sel;
            if (go_wr) begin
                din_q  <= sel_data;
                last_q <= sel_last;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else if (state_q == StRd) begin
            rx_valid_q <= 1'b1;
            rx_data_q  <= uart_dout;
            rx_perr_q  <= uart_perr;
            rx_ferr_q  <= uart_ferr;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
        end
    end

    assign uart_csn  = csn_q;
    assign uart_wen  = wen_q;
    assign uart_oen  = oen_q;
    assign uart_din  = din_q;
    assign tx0_ready = tx0_ready_q;
    assign tx1_ready = tx1_ready_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign rx_perr   = rx_perr_q;
    assign rx_ferr   = rx_ferr_q;

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Self-checking bench for uart_link_ctrl: scoreboarded TX writes and RX reads,
// arbitration order, latency, backpressure, priority collision and async reset.
module tb_uart_link_ctrl;

    localparam int unsigned G = 2;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    logic [7:0] tx0_data = 8'h00, tx1_data = 8'h00;
    logic       tx0_valid = 1'b0, tx1_valid = 1'b0;
    logic       tx0_last = 1'b0, tx1_last = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] uart_dout = 8'h00;
    logic       uart_txrdy = 1'b1, uart_rxrdy = 1'b0, uart_perr = 1'b0, uart_ferr = 1'b0;

    logic       tx0_ready, tx1_ready, rx_perr, rx_ferr, rx_valid;
    logic [7:0] rx_data, uart_din;
    logic       uart_csn, uart_wen, uart_oen, grant, lock;

    logic       b_tx0_ready, b_tx1_ready, b_rx_perr, b_rx_ferr, b_rx_valid;
    logic [7:0] b_rx_data, b_uart_din;
    logic       b_uart_csn, b_uart_wen, b_uart_oen, b_grant, b_lock;

    uart_link_ctrl #(.GUARD_CYCLES(G), .RX_PRIORITY(1'b1)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .tx0_data(tx0_data), .tx0_valid(tx0_valid), .tx0_last(tx0_last), .tx0_ready(tx0_ready),
        .tx1_data(tx1_data), .tx1_valid(tx1_valid), .tx1_last(tx1_last), .tx1_ready(tx1_ready),
        .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .uart_csn(uart_csn), .uart_wen(uart_wen), .uart_oen(uart_oen),
        .uart_din(uart_din), .uart_dout(uart_dout), .uart_txrdy(uart_txrdy),
        .uart_rxrdy(uart_rxrdy), .uart_perr(uart_perr), .uart_ferr(uart_ferr),
        .grant(grant), .lock(lock)
    );

    // TX-priority twin, only observed in the collision test.
    uart_link_ctrl #(.GUARD_CYCLES(G), .RX_PRIORITY(1'b0)) dut_b (
        .CLK(CLK), .RESET_N(RESET_N),
        .tx0_data(tx0_data), .tx0_valid(tx0_valid), .tx0_last(tx0_last), .tx0_ready(b_tx0_ready),
        .tx1_data(tx1_data), .tx1_valid(tx1_valid), .tx1_last(tx1_last), .tx1_ready(b_tx1_ready),
        .rx_data(b_rx_data), .rx_perr(b_rx_perr), .rx_ferr(b_rx_ferr), .rx_valid(b_rx_valid),
        .rx_ready(rx_ready), .uart_csn(b_uart_csn), .uart_wen(b_uart_wen),
        .uart_oen(b_uart_oen), .uart_din(b_uart_din), .uart_dout(uart_dout),
        .uart_txrdy(uart_txrdy), .uart_rxrdy(uart_rxrdy), .uart_perr(uart_perr),
        .uart_ferr(uart_ferr), .grant(b_grant), .lock(b_lock)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic       owner;
        logic       last;
        logic [7:0] data;
    } wr_exp_t;

    logic [8:0] tx0_src[$], tx1_src[$];   // {last, data}
    logic [9:0] rx_src[$], rx_exp[$];     // {perr, ferr, data}
    wr_exp_t    wr_exp[$];
    logic       rx_ready_want = 1'b0;

    logic took0 = 1'b0, took1 = 1'b0, rd_seen = 1'b0;
    int   n_rd = 0;
    int   cyc = 0;

    localparam logic [25:0] RstVec = {3'b111, 23'b0};

    function automatic logic [25:0] out_vec();
        return {uart_csn, uart_wen, uart_oen, uart_din, tx0_ready, tx1_ready, rx_valid,
                rx_data, rx_perr, rx_ferr, grant, lock};
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: sample at the falling edge, pop scoreboards on DUT activity.
    initial begin
        int      prev_cyc;
        bit      have_prev;
        bit      lock_pending;
        logic    exp_lock;
        wr_exp_t e;
        logic [9:0] r;
        have_prev = 0;
        lock_pending = 0;
        exp_lock = 0;
        prev_cyc = 0;
        forever begin
            @(negedge CLK);
            if (!RESET_N) begin
                have_prev = 0;
                lock_pending = 0;
            end else begin
                if (lock_pending) begin
                    check_eq("lock_after_accept", {31'b0, lock}, {31'b0, exp_lock});
                    lock_pending = 0;
                end
                if (!uart_csn) begin
                    if (have_prev)
                        check_eq("strobe_gap", {31'b0, (cyc - prev_cyc) >= int'(2 + G)}, 32'd1);
                    prev_cyc = cyc;
                    have_prev = 1;
                    if (!uart_wen) begin
                        if (wr_exp.size() == 0) begin
                            check_eq("unexpected_write", {24'b0, uart_din}, 32'hFFFF_FFFF);
                        end else begin
                            e = wr_exp.pop_front();
                            check_eq("wr_din", {24'b0, uart_din}, {24'b0, e.data});
                            check_eq("wr_ready", {30'b0, tx1_ready, tx0_ready},
                                     e.owner ? 32'd2 : 32'd1);
                            check_eq("wr_grant", {31'b0, grant}, {31'b0, e.owner});
                            exp_lock = ~e.last;
                            lock_pending = 1;
                        end
                        took0 = tx0_ready;
                        took1 = tx1_ready;
                    end
                    if (!uart_oen) begin
                        rd_seen = 1;
                        n_rd++;
                    end
                end
                if (rx_valid && rx_ready) begin
                    if (rx_exp.size() == 0) begin
                        check_eq("unexpected_rx", {22'b0, rx_perr, rx_ferr, rx_data}, 32'hFFFF_FFFF);
                    end else begin
                        r = rx_exp.pop_front();
                        check_eq("rx_byte", {22'b0, rx_perr, rx_ferr, rx_data}, {22'b0, r});
                    end
                end
            end
        end
    end

    // Requester and UART models: drive inputs just after the rising edge.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (took0 && tx0_src.size() > 0) void'(tx0_src.pop_front());
            if (took1 && tx1_src.size() > 0) void'(tx1_src.pop_front());
            if (rd_seen && rx_src.size() > 0) void'(rx_src.pop_front());
            took0 = 0;
            took1 = 0;
            rd_seen = 0;
            tx0_valid = tx0_src.size() > 0;
            {tx0_last, tx0_data} = (tx0_src.size() > 0) ? tx0_src[0] : 9'h0;
            tx1_valid = tx1_src.size() > 0;
            {tx1_last, tx1_data} = (tx1_src.size() > 0) ? tx1_src[0] : 9'h0;
            uart_rxrdy = rx_src.size() > 0;
            {uart_perr, uart_ferr, uart_dout} = (rx_src.size() > 0) ? rx_src[0] : 10'h0;
            rx_ready = rx_ready_want;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge CLK);
            #1;
            done = tx0_src.size() == 0 && tx1_src.size() == 0 && wr_exp.size() == 0 &&
                   rx_src.size() == 0;
        end
        if (!done) check_eq(tag, 32'd0, 32'd1);
        cycles(G + 3);
    endtask

    task automatic push_tx(input bit who, input bit last, input logic [7:0] d);
        wr_exp_t e;
        e.owner = who;
        e.last  = last;
        e.data  = d;
        if (who) tx1_src.push_back({last, d});
        else     tx0_src.push_back({last, d});
        wr_exp.push_back(e);
    endtask

    task automatic push_rx(input logic [9:0] v);
        rx_src.push_back(v);
        rx_exp.push_back(v);
    endtask

    initial begin
        int snap;
        bit seen;
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        bit seen;
        cycles(3);
        check_eq("reset_values", {6'b0, out_vec()}, {6'b0, RstVec});
        RESET_N = 1'b1;
        cycles(2);

        // Single byte: WR two cycles after queueing (model applies, then IDLE decides).
        push_tx(1'b0, 1'b1, 8'hA5);
        cycles(1);
        check_eq("tx_not_early", {31'b0, uart_wen}, 32'd1);
        cycles(1);
        check_eq("tx_latency", {31'b0, uart_wen}, 32'd0);
        wait_drain("drain_single", 40);

        // Packet lock: tx0 starts alone, tx1 joins and must wait for tx0's last byte.
        push_tx(1'b0, 1'b0, 8'h11);
        push_tx(1'b0, 1'b0, 8'h22);
        push_tx(1'b0, 1'b1, 8'h33);
        cycles(1);
        push_tx(1'b1, 1'b1, 8'h44);
        wait_drain("drain_lock", 80);

        // Round-robin with single-byte packets: 0,1,0,1.
        tx0_src.push_back({1'b1, 8'h55});
        tx1_src.push_back({1'b1, 8'h77});
        tx0_src.push_back({1'b1, 8'h66});
        tx1_src.push_back({1'b1, 8'h88});
        wr_exp.push_back('{1'b0, 1'b1, 8'h55});
        wr_exp.push_back('{1'b1, 1'b1, 8'h77});
        wr_exp.push_back('{1'b0, 1'b1, 8'h66});
        wr_exp.push_back('{1'b1, 1'b1, 8'h88});
        wait_drain("drain_rr", 80);

        // RX capture with parity error, held until consumed.
        push_rx({1'b1, 1'b0, 8'h3C});
        cycles(2);
        check_eq("rx_rd_strobe", {30'b0, uart_csn, uart_oen}, 32'd0);
        check_eq("rx_not_early", {31'b0, rx_valid}, 32'd0);
        cycles(1);
        check_eq("rx_latency", {21'b0, rx_valid, rx_perr, rx_ferr, rx_data},
                 {21'b0, 1'b1, 1'b1, 1'b0, 8'h3C});
        cycles(5);
        check_eq("rx_hold", {23'b0, rx_valid, rx_data}, {23'b0, 1'b1, 8'h3C});

        // Backpressure: full buffer blocks the next read entirely.
        push_rx({1'b0, 1'b1, 8'hC3});
        snap = n_rd;
        cycles(20);
        check_eq("no_oen_while_full", n_rd - snap, 32'd0);
        rx_ready_want = 1'b1;
        cycles(2);
        check_eq("rd_on_empty", {31'b0, uart_oen}, 32'd0);
        wait_drain("drain_rx", 40);
        check_eq("rx_all_consumed", rx_exp.size(), 32'd0);

        // Fresh start for the collision test so both twins share a known state.
        RESET_N = 1'b0;
        cycles(2);
        RESET_N = 1'b1;
        cycles(2);
        push_rx({1'b0, 1'b0, 8'h5A});
        push_tx(1'b0, 1'b1, 8'hBE);
        cycles(2);
        check_eq("coll_rx_first", {30'b0, uart_oen, uart_wen}, 32'd1);
        check_eq("coll_b_tx_first", {30'b0, b_uart_oen, b_uart_wen}, 32'd2);
        cycles(G + 2);
        check_eq("coll_wr_after_guard", {31'b0, uart_wen}, 32'd0);
        wait_drain("drain_coll", 40);
        check_eq("coll_rx_consumed", rx_exp.size(), 32'd0);

        // Async reset during GUARD with buffer full, lock and grant set.
        rx_ready_want = 1'b0;
        rx_src.push_back({1'b0, 1'b1, 8'h77});
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge CLK);
            #1;
            seen = rx_valid;
        end
        check_eq("pre_reset_rx_full", {31'b0, seen}, 32'd1);
        push_tx(1'b1, 1'b0, 8'h9C);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge CLK);
            #1;
            seen = wr_exp.size() == 0;
        end
        check_eq("pre_reset_write", {31'b0, seen}, 32'd1);
        cycles(1);
        #2;
        check_eq("pre_reset_state", {29'b0, grant, lock, rx_valid}, 32'd7);
        RESET_N = 1'b0;
        #1;
        check_eq("async_reset", {6'b0, out_vec()}, {6'b0, RstVec});
        tx0_src.delete();
        tx1_src.delete();
        rx_src.delete();
        cycles(2);
        check_eq("reset_held", {6'b0, out_vec()}, {6'b0, RstVec});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
